// File: rtl/mu0_io_bridge_if.sv
// MU0 bridge interfaces: processor/RAM bus
// and the valid/ready output stream.
interface mu0_bus_if;
  logic [11:0] Addr;
  logic        Rd;
  logic        Wr;
  logic [15:0] Wdata;
  logic [15:0] Rdata;

  modport master (
    output Addr, Rd, Wr, Wdata,
    input  Rdata
  );

  modport slave (
    input  Addr, Rd, Wr, Wdata,
    output Rdata
  );
endinterface

interface mu0_stream_if;
  logic [15:0] Data;
  logic        Valid;
  logic        Ready;

  modport master (
    output Data, Valid,
    input  Ready
  );

  modport slave (
    input  Data, Valid,
    output Ready
  );
endinterface

// File: rtl/mu0_io_bridge.sv
// MU0 address decode stage: RAM pass-through
// plus an I/O page with output FIFO, status, counter, switches.
module mu0_io_bridge #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] IO_BASE    = 12'hFF0
) (
  input  logic        Clk,
  input  logic        Reset,
  mu0_bus_if.slave    Cpu,
  mu0_bus_if.master   Mem,
  input  logic        Halted,
  input  logic [15:0] Sw,
  mu0_stream_if.master Out,
  output logic        Fifo_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic        io_sel;
  logic [3:0]  off;
  logic        wr_io;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        ovf_set;
  logic        ovf_clr;
  logic        cyc_ld;
  logic [4:0]  cnt5;
  logic [15:0] status;
  logic [15:0] io_rdata;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [15:0]   sync1_q, sync2_q;

  assign io_sel = (Cpu.Addr[11:4] == IO_BASE[11:4]);
  assign off    = Cpu.Addr[3:0];

  assign Mem.Addr  = Cpu.Addr;
  assign Mem.Wdata = Cpu.Wdata;
  assign Mem.Rd    = Cpu.Rd & ~io_sel;
  assign Mem.Wr    = Cpu.Wr & ~io_sel;

  assign wr_io    = Cpu.Wr & io_sel;
  assign push_req = wr_io & (off == 4'd0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = Out.Valid & Out.Ready;
  // A full FIFO still accepts a push when it drains that cycle
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr_io & (off == 4'd1)
                  & Cpu.Wdata[2];
  assign cyc_ld   = wr_io & (off == 4'd2);

  assign Out.Valid     = ~empty;
  assign Out.Data      = mem_q[rd_ptr_q];
  assign Fifo_Overflow = ovf_q;

  assign cnt5   = 5'(cnt_q);
  assign status = {7'b0, cnt5, 1'b0,
                   ovf_q, full, empty};

  always_comb begin
    io_rdata = '0;
    case (off)
      4'd1:    io_rdata = status;
      4'd2:    io_rdata = cyc_q;
      4'd3:    io_rdata = sync2_q;
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    Cpu.Rdata = '0;
    if (Cpu.Rd)
      Cpu.Rdata = io_sel ? io_rdata
                         : Mem.Rdata;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    cyc_d = cyc_q;
    if (!Halted) cyc_d = cyc_q + 16'd1;
    if (cyc_ld)  cyc_d = Cpu.Wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
      sync1_q  <= Sw;
      sync2_q  <= sync1_q;
      if (push)
        mem_q[wr_ptr_q] <= Cpu.Wdata;
    end
  end

endmodule

// File: tb/tb_mu0_io_bridge.sv
// Directed bench for mu0_io_bridge with
// hand-computed expectations.
module tb_mu0_io_bridge;

  logic        Clk;
  logic        Reset;
  logic        Halted;
  logic [15:0] Sw;
  logic        Fifo_Overflow;

  int n_cmp;
  int n_bad;

  mu0_bus_if    cpu ();
  mu0_bus_if    mem ();
  mu0_stream_if out ();

  mu0_io_bridge #(
    .FIFO_DEPTH (8),
    .IO_BASE    (12'hFF0)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Cpu           (cpu.slave),
    .Mem           (mem.master),
    .Halted        (Halted),
    .Sw            (Sw),
    .Out           (out.master),
    .Fifo_Overflow (Fifo_Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic io_wr(
    input logic [11:0] a,
    input logic [15:0] d
  );
    cpu.Addr  = a;
    cpu.Wdata = d;
    cpu.Wr    = 1'b1;
    tick();
    cpu.Wr    = 1'b0;
  endtask

  task automatic rd(
    input  logic [11:0] a,
    output logic [15:0] d
  );
    cpu.Addr = a;
    cpu.Rd   = 1'b1;
    #1;
    d = cpu.Rdata;
    cpu.Rd   = 1'b0;
  endtask

  logic [15:0] v;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    Reset     = 1'b1;
    Halted    = 1'b0;
    Sw        = '0;
    cpu.Addr  = '0;
    cpu.Rd    = 1'b0;
    cpu.Wr    = 1'b0;
    cpu.Wdata = '0;
    mem.Rdata = '0;
    out.Ready = 1'b0;
    tick();
    tick();
    Reset = 1'b0;

    chk("rst_valid", 16'(out.Valid), 16'd0);
    chk("rst_data", out.Data, 16'h0000);
    chk("rst_ovf", 16'(Fifo_Overflow), 16'd0);
    rd(12'hFF1, v);
    chk("rst_status", v, 16'h0001);

    // RAM pass-through
    cpu.Addr  = 12'h123;
    cpu.Wdata = 16'hBEEF;
    cpu.Wr    = 1'b1;
    #1;
    chk("mem_wr", 16'(mem.Wr), 16'd1);
    chk("mem_addr", 16'(mem.Addr), 16'h0123);
    chk("mem_wdata", mem.Wdata, 16'hBEEF);
    cpu.Wr    = 1'b0;
    mem.Rdata = 16'hBEEF;
    #1;
    chk("rdata_idle", cpu.Rdata, 16'h0000);
    cpu.Rd = 1'b1;
    #1;
    chk("mem_rd", 16'(mem.Rd), 16'd1);
    chk("ram_rdata", cpu.Rdata, 16'hBEEF);
    cpu.Addr = 12'hFF2;
    #1;
    chk("io_no_memrd", 16'(mem.Rd), 16'd0);
    cpu.Rd = 1'b0;
    cpu.Addr = 12'hFF0;
    cpu.Wr = 1'b1;
    #1;
    chk("io_no_memwr", 16'(mem.Wr), 16'd0);
    cpu.Wr = 1'b0;

    // FIFO ordering
    io_wr(12'hFF0, 16'd1);
    io_wr(12'hFF0, 16'd2);
    io_wr(12'hFF0, 16'd3);
    rd(12'hFF1, v);
    chk("ord_status", v, 16'h0030);
    rd(12'hFF0, v);
    chk("fifo_rd0", v, 16'h0000);
    rd(12'hFF7, v);
    chk("unmapped_rd", v, 16'h0000);
    out.Ready = 1'b1;
    #1;
    chk("ord_d1", out.Data, 16'd1);
    tick();
    chk("ord_d2", out.Data, 16'd2);
    tick();
    chk("ord_d3", out.Data, 16'd3);
    tick();
    chk("ord_empty", 16'(out.Valid), 16'd0);
    out.Ready = 1'b0;
    rd(12'hFF1, v);
    chk("ord_status2", v, 16'h0001);

    // Overflow
    for (int i = 0; i < 9; i++)
      io_wr(12'hFF0, 16'(16'h10 + i));
    rd(12'hFF1, v);
    chk("ovf_status", v, 16'h0086);
    chk("ovf_flag", 16'(Fifo_Overflow), 16'd1);
    out.Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("ovf_d%0d", i),
          out.Data, 16'(16'h10 + i));
      tick();
    end
    chk("ovf_drained", 16'(out.Valid), 16'd0);
    out.Ready = 1'b0;
    io_wr(12'hFF1, 16'h0004);
    chk("ovf_clr", 16'(Fifo_Overflow), 16'd0);
    rd(12'hFF1, v);
    chk("ovf_clr_st", v, 16'h0001);

    // Full push + pop same cycle
    for (int i = 0; i < 8; i++)
      io_wr(12'hFF0, 16'(16'h20 + i));
    out.Ready = 1'b1;
    io_wr(12'hFF0, 16'h00AA);
    out.Ready = 1'b0;
    chk("pp_ovf", 16'(Fifo_Overflow), 16'd0);
    rd(12'hFF1, v);
    chk("pp_status", v, 16'h0082);
    out.Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("pp_d%0d", i), out.Data,
          (i == 7) ? 16'h00AA
                   : 16'(16'h21 + i));
      tick();
    end
    chk("pp_empty", 16'(out.Valid), 16'd0);
    out.Ready = 1'b0;

    // Cycle counter
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (10) tick();
    rd(12'hFF2, v);
    chk("cnt_10", v, 16'd10);
    Halted = 1'b1;
    repeat (5) tick();
    rd(12'hFF2, v);
    chk("cnt_halt", v, 16'd10);
    Halted = 1'b0;
    io_wr(12'hFF2, 16'hFFFF);
    rd(12'hFF2, v);
    chk("cnt_load", v, 16'hFFFF);
    tick();
    tick();
    rd(12'hFF2, v);
    chk("cnt_wrap", v, 16'h0001);
    io_wr(12'hFF5, 16'h1234);
    rd(12'hFF5, v);
    chk("unmapped_wr", v, 16'h0000);

    // Reset mid-operation
    Halted = 1'b1;
    for (int i = 0; i < 9; i++)
      io_wr(12'hFF0, 16'(16'h40 + i));
    out.Ready = 1'b1;
    repeat (5) tick();
    out.Ready = 1'b0;
    io_wr(12'hFF2, 16'h0055);
    rd(12'hFF1, v);
    chk("pre_status", v, 16'h0034);
    rd(12'hFF2, v);
    chk("pre_cnt", v, 16'h0055);
    Reset     = 1'b1;
    out.Ready = 1'b1;
    cpu.Addr  = 12'hFF0;
    cpu.Wdata = 16'h7777;
    cpu.Wr    = 1'b1;
    tick();
    Reset     = 1'b0;
    out.Ready = 1'b0;
    cpu.Wr    = 1'b0;
    chk("mr_valid", 16'(out.Valid), 16'd0);
    chk("mr_data", out.Data, 16'h0000);
    chk("mr_ovf", 16'(Fifo_Overflow), 16'd0);
    rd(12'hFF1, v);
    chk("mr_status", v, 16'h0001);
    rd(12'hFF2, v);
    chk("mr_cnt", v, 16'h0000);
    Halted = 1'b0;

    // Switch synchroniser
    Sw = 16'h5A5A;
    tick();
    rd(12'hFF3, v);
    chk("sw_1cyc", v, 16'h0000);
    tick();
    rd(12'hFF3, v);
    chk("sw_2cyc", v, 16'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mu0_io_bridge.md
Name: mu0_io_bridge

Overview:
- Address-decoding bus stage directly downstream of the MU0 processor, between its memory interface (Rd/Wr/Addr/Data_out/Data_in) and system RAM plus on-chip I/O.
- Passes non-I/O accesses through to RAM.
- Implements a memory-mapped I/O page: an output FIFO drained by a valid/ready peripheral port, a status register, a free-running cycle counter and a synchronised switch input.

Parameters:
- FIFO_DEPTH, 8, output FIFO entries; power of two, 2..16.
- IO_BASE, 12'hFF0, base of 16-word I/O page; must be a multiple of 16.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Cpu_Addr  in  12  address from processor
- Cpu_Rd  in  1  processor read strobe
- Cpu_Wr  in  1  processor write strobe
- Cpu_Wdata  in  16  processor write data (processor Data_out)
- Cpu_Rdata  out  16  read data to processor (processor Data_in)
- Halted  in  1  processor halted flag
- Mem_Addr  out  12  RAM address
- Mem_Rd  out  1  RAM read strobe
- Mem_Wr  out  1  RAM write strobe
- Mem_Wdata  out  16  RAM write data
- Mem_Rdata  in  16  RAM read data
- Sw  in  16  asynchronous switch inputs
- Out_Data  out  16  FIFO head word
- Out_Valid  out  1  FIFO non-empty
- Out_Ready  in  1  peripheral accepts head word
- Fifo_Overflow  out  1  sticky: a push was dropped

Behaviour:
- Decode: io_sel = (Cpu_Addr[11:4] == IO_BASE[11:4]).
- Mem_Addr = Cpu_Addr and Mem_Wdata = Cpu_Wdata, always.
- Mem_Rd = Cpu_Rd & ~io_sel; Mem_Wr = Cpu_Wr & ~io_sel.
- Cpu_Rdata is combinational, same cycle as Cpu_Rd: Mem_Rdata when ~io_sel, else the I/O register below; 16'h0000 when Cpu_Rd is low.
- I/O map (offset from IO_BASE):
  - 0: FIFO data. Write pushes Cpu_Wdata. Read returns 0.
  - 1: status, read. bit0 empty, bit1 full, bit2 Fifo_Overflow, bits[8:4] count, others 0. Write with Cpu_Wdata[2]=1 clears Fifo_Overflow; other write bits are ignored.
  - 2: cycle counter. Read returns value; write loads Cpu_Wdata.
  - 3: Sw after two-flop synchroniser (2-cycle latency). Read only.
  - 4..15: read 0; writes ignored.
- Output FIFO: circular buffer, write/read pointers, count 0..FIFO_DEPTH.
  - Out_Valid = (count != 0); Out_Data = mem[rd_ptr], combinational from registered state.
  - Pop when Out_Valid & Out_Ready.
  - Push when the offset-0 write is accepted: (count < FIFO_DEPTH) OR pop in the same cycle.
  - Full with push and pop in the same cycle: both occur, count unchanged.
  - Empty with push: pop impossible that cycle; word visible on Out_Data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full without a pop: word dropped, FIFO unchanged, Fifo_Overflow set next edge.
- Fifo_Overflow: sticky until cleared by a status write or Reset. If a clear and a new overflow occur in the same cycle, set wins.
- Cycle counter: 16-bit; increments each cycle while Halted=0; frozen while Halted=1; wraps FFFF->0000. A write load takes priority over the increment that cycle.
- Cpu_Rd and Cpu_Wr both high: write takes effect and read data is still driven (processor never does this; must not corrupt state).
- Reset values (next edge with Reset=1, regardless of activity):
  - FIFO emptied, pointers 0.
  - Out_Valid=0, Out_Data=0 (storage cleared).
  - Fifo_Overflow=0, counter=0, synchroniser flops=0.
  - Mem_* remain combinational pass-through.
- Any in-flight push or pop in a reset cycle is discarded.

Test Plan:
- RAM pass-through: Cpu_Wr=1, Addr=12'h123, Wdata=16'hBEEF -> Mem_Wr=1, Mem_Addr=123, Mem_Wdata=BEEF. Then Cpu_Rd at 12'h123 with Mem_Rdata=BEEF -> Cpu_Rdata=BEEF same cycle. Cpu_Rd at 12'hFF2 -> Mem_Rd=0.
- FIFO ordering: Out_Ready=0; write 1,2,3 to FF0 -> status read = 16'h0030. Raise Out_Ready -> Out_Data 1,2,3 on consecutive cycles, then Out_Valid=0 and status=16'h0001.
- Overflow: Out_Ready=0; 9 writes (0x10..0x18) -> status=16'h0086 (full, overflow, count 8); drained data 0x10..0x17, 0x18 absent. Write 16'h0004 to FF1 -> overflow=0.
- Full push+pop: FIFO full, Out_Ready=1 and FF0 write of 0xAA same cycle -> no overflow, count stays 8, 0xAA emerges last.
- Counter: Reset, 10 cycles with Halted=0 -> read FF2 = 10. Halted=1 for 5 cycles -> still 10. Write FFFF, 2 cycles later -> 0001.
- Reset mid-operation: FIFO holding 3 words, counter=0x55, overflow set; Reset one cycle -> Out_Valid=0, status=16'h0001, counter=0. Sw=16'h5A5A -> FF3 reads 5A5A two cycles after Sw changes.
